// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: divisor width and FSM encoding.
package uart_tx_buffered_pkg;
  localparam int UART_DIV_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with first-word fall-through read; full/empty come from pointer MSBs.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [FIFO_DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [7:0]                 mem [DEPTH];
  logic                       do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= din;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end, LSB-first serialiser, flop-driven TX pin.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [UART_DIV_W-1:0] bit_rate_divisor,
  input  logic [7:0]            data,
  input  logic                  data_ready,
  output logic                  ready,
  output logic                  busy,
  output logic                  UART_TX
);
  tx_state_e             state, state_n;
  logic [UART_DIV_W-1:0] bit_timer, bit_timer_n;
  logic [UART_DIV_W-1:0] div_q, div_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [7:0]            shift_reg, shift_n;
  logic                  tx_q, tx_n;
  logic                  busy_q;
  logic                  bit_end, pop;
  logic                  fifo_empty, fifo_full;
  logic [7:0]            fifo_dout;

  uart_tx_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_ready),
    .din     (data),
    .pop     (pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign ready   = ~fifo_full;
  assign busy    = busy_q;
  assign UART_TX = tx_q;
  assign bit_end = (bit_timer == div_q);

  always_comb begin
    state_n     = state;
    bit_timer_n = bit_timer;
    div_n       = div_q;
    bit_idx_n   = bit_idx;
    shift_n     = shift_reg;
    tx_n        = tx_q;
    pop         = 1'b0;
    if (state != ST_IDLE) bit_timer_n = bit_end ? '0 : bit_timer + 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_n     = fifo_dout;
          div_n       = bit_rate_divisor;
          bit_timer_n = '0;
          tx_n        = 1'b0;
          state_n     = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_n      = shift_reg[0];
          bit_idx_n = 3'd0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx != 3'd7) begin
            shift_n   = shift_reg >> 1;
            tx_n      = shift_reg[1];
            bit_idx_n = bit_idx + 3'd1;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit so queued bytes leave with no idle gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            div_n   = bit_rate_divisor;
            tx_n    = 1'b0;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_timer <= '0;
      div_q     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_timer <= bit_timer_n;
      div_q     <= div_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      tx_q      <= tx_n;
      busy_q    <= (state != ST_IDLE) | ~fifo_empty;
    end
  end
endmodule
